// File: rtl/golomb_pkg.sv
// Shared types and helpers for the Golomb ruler mark-counter chain.
package golomb_pkg;

  typedef enum logic [1:0] {IDLE, STEP, CHECK, DONE} state_t;

  localparam int DEF_WIDTH    = 9;
  localparam int DEF_MAXVALUE = 500;
  localparam int MARKBUS_W    = 1024;
  localparam int MARK_W       = 32;

  // Mark i of a flat bus of w-bit marks, zero-extended to MARK_W bits.
  function automatic logic [MARK_W-1:0] mark_at(input logic [MARKBUS_W-1:0] marks,
                                                input int unsigned i,
                                                input int unsigned w);
    logic [MARKBUS_W-1:0] sh;
    sh = marks >> (i * w);
    return sh[MARK_W-1:0] & ((MARK_W'(1) << w) - MARK_W'(1));
  endfunction

endpackage

// File: rtl/golomb_distance_checker.sv
// Serial clash checker: one mark per step, tracks distances claimed by the current candidate.
module golomb_distance_checker #(
  parameter int WIDTH    = golomb_pkg::DEF_WIDTH,
  parameter int MAXVALUE = golomb_pkg::DEF_MAXVALUE,
  parameter int LEVEL    = 5,
  parameter int IW       = $clog2(LEVEL + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              step,
  input  logic [WIDTH-1:0]  val,
  input  logic [WIDTH-1:0]  mark,
  input  logic [MAXVALUE:0] distances,
  output logic              clash,
  output logic              last,
  output logic [IW-1:0]     idx
);

  logic [MAXVALUE:0] pd;
  logic [WIDTH-1:0]  d;
  logic              in_table;

  assign d        = val - mark;
  assign in_table = (32'(d) <= MAXVALUE);
  assign last     = (idx == IW'(LEVEL - 1));

  always_comb begin
    clash = 1'b0;
    if (mark >= val) clash = 1'b1;
    else if (in_table) clash = distances[d] | pd[d];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pd  <= '0;
      idx <= IW'(1);
    end else if (clear) begin
      pd  <= '0;
      idx <= IW'(1);
    end else if (step) begin
      // distances beyond the table can never clash, so they are not recorded
      if (in_table) pd[d] <= 1'b1;
      idx <= idx + IW'(1);
    end
  end

endmodule

// File: rtl/mark_counter_leaf_seq.sv
// Last-mark counter of the Golomb ruler search: advances one candidate and checks it serially.
// Optional MARK_LEAF_AUTOSCAN_EN: clashing candidates are skipped internally without a done pulse.
module mark_counter_leaf_seq
  import golomb_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUMMARKS = 6,
  parameter int LEVEL    = 5,
  parameter int MAXVALUE = DEF_MAXVALUE,
  parameter int LEVEL_W  = 7
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load,
  input  logic [WIDTH-1:0]          resetvalue,
  input  logic                      start,
  input  logic [WIDTH-1:0]          startvalue,
  input  logic [WIDTH-1:0]          limit,
  input  logic [NUMMARKS*WIDTH-1:0] marks_in,
  input  logic [MAXVALUE:0]         distances,
  output logic                      ready,
  output logic                      done,
  output logic                      success,
  output logic [WIDTH-1:0]          val,
  output logic [LEVEL_W-1:0]        nextEnabled
);

  localparam int IW = $clog2(LEVEL + 1);

  state_t                    state_q, state_d;
  logic [WIDTH-1:0]          limit_q;
  logic [NUMMARKS*WIDTH-1:0] marks_q;
  logic [MAXVALUE:0]         dist_q;
  logic [WIDTH:0]            cand;
  logic                      cand_bad;
  logic                      chk_clear, chk_step, clash, last;
  logic [IW-1:0]             idx;
  logic [MARKBUS_W-1:0]      marks_ext;
  logic [MARK_W-1:0]         mark_full;
  logic [WIDTH-1:0]          cur_mark;

  // one extra bit catches the wrap past the largest representable position
  assign cand      = (val == '0) ? {1'b0, startvalue} : ({1'b0, val} + (WIDTH+1)'(1));
  assign cand_bad  = cand[WIDTH] | (cand[WIDTH-1:0] > limit_q);
  assign marks_ext = {{(MARKBUS_W-NUMMARKS*WIDTH){1'b0}}, marks_q};
  assign mark_full = mark_at(marks_ext, 32'(idx), WIDTH);
  assign cur_mark  = mark_full[WIDTH-1:0];

  assign ready = (state_q == IDLE);
  assign done  = (state_q == DONE);

  golomb_distance_checker #(
    .WIDTH(WIDTH), .MAXVALUE(MAXVALUE), .LEVEL(LEVEL), .IW(IW)
  ) u_chk (
    .clock    (clock),
    .reset    (reset),
    .clear    (chk_clear),
    .step     (chk_step),
    .val      (val),
    .mark     (cur_mark),
    .distances(dist_q),
    .clash    (clash),
    .last     (last),
    .idx      (idx)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    chk_clear = 1'b0;
    chk_step  = 1'b0;
    case (state_q)
      IDLE:  if (!load && start) state_d = STEP;
      STEP: begin
        if (cand_bad || (LEVEL == 1)) state_d = DONE;
        else begin
          chk_clear = 1'b1;
          state_d   = CHECK;
        end
      end
      CHECK: begin
        if (clash) begin
`ifdef MARK_LEAF_AUTOSCAN_EN
          state_d = STEP;
`else
          state_d = DONE;
`endif
        end else begin
          chk_step = 1'b1;
          if (last) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      val         <= '0;
      success     <= 1'b0;
      nextEnabled <= LEVEL_W'(LEVEL);
      limit_q     <= '0;
      marks_q     <= '0;
      dist_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) val <= resetvalue;
          else if (start) begin
            limit_q <= limit;
            marks_q <= marks_in;
            dist_q  <= distances;
          end
        end
        STEP: begin
          if (cand_bad) begin
            val         <= '0;
            success     <= 1'b0;
            nextEnabled <= LEVEL_W'(LEVEL - 1);
          end else begin
            val <= cand[WIDTH-1:0];
            if (LEVEL == 1) begin
              success     <= 1'b1;
              nextEnabled <= LEVEL_W'(LEVEL);
            end
          end
        end
        CHECK: begin
          if (clash) begin
`ifndef MARK_LEAF_AUTOSCAN_EN
            success     <= 1'b0;
            nextEnabled <= LEVEL_W'(LEVEL);
`endif
          end else if (last) begin
            success     <= 1'b1;
            nextEnabled <= LEVEL_W'(LEVEL);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mark_counter_leaf_seq.sv
// Bench for mark_counter_leaf_seq: ruler-rule model plus per-cycle output comparison.
module tb_mark_counter_leaf_seq;

  localparam int W = 9, NM = 4, LV = 3, MV = 500, LW = 7;
  localparam int WMAX = (1 << W) - 1;

  logic clock = 1'b0, reset = 1'b0, load = 1'b0, start = 1'b0;
  logic [W-1:0] resetvalue = '0, startvalue = '0, limit = '0;
  logic [NM*W-1:0] marks_in;
  logic [MV:0] distances;
  logic ready, done, success;
  logic [W-1:0] val;
  logic [LW-1:0] nextEnabled;

  int checks = 0, failures = 0, cyc = 0;
  int m_val = 0, m_succ = 0, m_ne = LV;
  int r_start = -1, r_done = -1, r_val = 0, r_succ = 0, r_ne = 0;
  int l_cyc = -1, l_val = 0;
  int mk[NM] = '{0, 1, 3, 0};
  int lat;

  mark_counter_leaf_seq #(.WIDTH(W), .NUMMARKS(NM), .LEVEL(LV), .MAXVALUE(MV), .LEVEL_W(LW)) dut (
    .clock(clock), .reset(reset), .load(load), .resetvalue(resetvalue), .start(start),
    .startvalue(startvalue), .limit(limit), .marks_in(marks_in), .distances(distances),
    .ready(ready), .done(done), .success(success), .val(val), .nextEnabled(nextEnabled)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Walks candidates by the ruler rules; lat counts clock edges from the accepting edge to done.
  function automatic void model(input int v0, input int sv, input int lim,
                                output int rv, output int rs, output int rn, output int lt);
    int v, cand, d, m;
    bit clash, fin;
    bit used[0:MV];
    v = v0; lt = 1; fin = 0;
    rv = 0; rs = 0; rn = LV;
    while (!fin) begin
      cand = (v == 0) ? sv : v + 1;
      lt++;
      if (cand > lim || cand > WMAX) begin
        rv = 0; rs = 0; rn = LV - 1; fin = 1;
      end else begin
        v = cand; clash = 0;
        for (int j = 0; j <= MV; j++) used[j] = 0;
        for (int k = 1; k < LV && !clash; k++) begin
          m = mk[k];
          d = (v - m) & WMAX;
          lt++;
          if (m >= v || (d <= MV && (distances[d] || used[d]))) clash = 1;
          else if (d <= MV) used[d] = 1;
        end
        if (!clash) begin
          rv = v; rs = 1; rn = LV; fin = 1;
        end else begin
`ifndef MARK_LEAF_AUTOSCAN_EN
          rv = v; rs = 0; rn = LV; fin = 1;
`endif
        end
      end
    end
  endfunction

  // Per-cycle compare against the model state.
  initial begin
    bit busy;
    forever begin
      @(negedge clock);
      if (!reset) begin
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_val", val, 0);
        chk("rst_success", success, 0);
        chk("rst_next", nextEnabled, LV);
        m_val = 0; m_succ = 0; m_ne = LV; r_done = -1; l_cyc = -1;
      end else begin
        if (cyc == l_cyc) m_val = l_val;
        busy = (r_done >= 0) && (cyc > r_start) && (cyc <= r_done);
        chk("ready", ready, !busy);
        chk("done", done, (cyc == r_done));
        if (cyc == r_done) begin
          m_val = r_val; m_succ = r_succ; m_ne = r_ne;
        end
        if (!busy || cyc == r_done) begin
          chk("val", val, m_val);
          chk("success", success, m_succ);
          chk("next", nextEnabled, m_ne);
        end
      end
    end
  end

  task automatic issue(input int sv, input int lim, output int lt);
    int rv, rs, rn;
    model(m_val, sv, lim, rv, rs, rn, lt);
    r_val = rv; r_succ = rs; r_ne = rn;
    r_start = cyc; r_done = cyc + lt;
    startvalue = W'(sv); limit = W'(lim); start = 1'b1;
    @(posedge clock); #2;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (cyc <= r_done && n < 200) begin
      @(posedge clock); #2;
      n++;
    end
    chk({nm, "_timeout"}, (n < 200), 1);
  endtask

  task automatic do_load(input int v);
    load = 1'b1; resetvalue = W'(v);
    l_cyc = cyc + 1; l_val = v;
    @(posedge clock); #2;
    load = 1'b0;
    @(posedge clock); #2;
  endtask

  initial begin
    for (int i = 0; i < NM; i++) marks_in[i*W +: W] = W'(mk[i]);
    distances = '0;
    distances[1] = 1'b1; distances[2] = 1'b1; distances[3] = 1'b1;

    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock); #2;

`ifndef MARK_LEAF_AUTOSCAN_EN
    issue(4, 10, lat); chk("lat_v4", lat, 3); wait_idle("v4");
    chk("lit_v4", val, 4); chk("lit_s4", success, 0); chk("lit_n4", nextEnabled, 3);
    issue(4, 10, lat); chk("lat_v5", lat, 4); wait_idle("v5");
    chk("lit_v5", val, 5); chk("lit_s5", success, 0);
    issue(4, 10, lat); chk("lat_v6", lat, 4); wait_idle("v6");
    chk("lit_v6", val, 6); chk("lit_s6", success, 0);
    issue(4, 10, lat); chk("lat_v7", lat, 4); wait_idle("v7");
    chk("lit_v7", val, 7); chk("lit_s7", success, 1); chk("lit_n7", nextEnabled, 3);
`else
    issue(4, 10, lat); chk("lat_scan", lat, 12); wait_idle("scan");
    chk("lit_scan_v", val, 7); chk("lit_scan_s", success, 1); chk("lit_scan_n", nextEnabled, 3);
`endif

    // limit exit
    do_load(10);
    chk("lit_load10", val, 10);
    issue(4, 10, lat); chk("lat_lim", lat, 2); wait_idle("lim");
    chk("lit_lim_v", val, 0); chk("lit_lim_s", success, 0); chk("lit_lim_n", nextEnabled, 2);

    // carry-out of the candidate
    do_load(511);
    issue(4, 511, lat); chk("lat_ovf", lat, 2); wait_idle("ovf");
    chk("lit_ovf_v", val, 0); chk("lit_ovf_n", nextEnabled, 2);

    // reset while checking: no done may follow
    issue(7, 10, lat);
    @(posedge clock); #2;
    reset = 1'b0;
    repeat (2) begin @(posedge clock); #2; end
    reset = 1'b1;
    repeat (4) begin @(posedge clock); #2; end
    chk("lit_abort_ready", ready, 1); chk("lit_abort_val", val, 0);

    // start while busy is ignored
    issue(4, 10, lat);
    start = 1'b1;
    @(posedge clock); #2;
    start = 1'b0;
    wait_idle("busy");
`ifndef MARK_LEAF_AUTOSCAN_EN
    chk("lit_busy_v", val, 4);
`else
    chk("lit_busy_v", val, 7);
`endif
    repeat (3) begin @(posedge clock); #2; end

    // load wins over start
    load = 1'b1; start = 1'b1; resetvalue = W'(20); startvalue = W'(4); limit = W'(30);
    l_cyc = cyc + 1; l_val = 20;
    @(posedge clock); #2;
    load = 1'b0; start = 1'b0;
    repeat (4) begin @(posedge clock); #2; end
    chk("lit_ldst_v", val, 20); chk("lit_ldst_ready", ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
